// File: rtl/ov7670_stream_gen.sv
// OV7670 parallel-bus stand-in: emits PCLK/HREF/VSYNC/D framing with RGB565 test patterns,
// two bytes per pixel (high byte first), so the capture path can run without a sensor.
module ov7670_stream_gen #(
  parameter int unsigned H_ACTIVE    = 320,
  parameter int unsigned V_ACTIVE    = 240,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern,
  input  logic [15:0] solid_color,
  output logic        CAM_PCLK,
  output logic        CAM_HREF,
  output logic        CAM_VSYNC,
  output logic [7:0]  CAM_D,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned ACT_BYTES = 2 * H_ACTIVE;
  localparam int unsigned BAR_W     = H_ACTIVE / 8;
  localparam int unsigned BC_W      = $clog2(LINE_LEN);
  localparam int unsigned MAX_AB    = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int unsigned MAX_CD    = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int unsigned MAX_LINES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned LC_W      = $clog2(MAX_LINES + 1);
  localparam int unsigned SEG_W     = $clog2(BAR_W + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBACK  = 3'd2,
    S_ACTIVE = 3'd3,
    S_VFRONT = 3'd4
  } state_e;

  // Zero-length vertical regions are skipped when choosing the successor state.
  localparam state_e AFTER_VBACK = (V_ACTIVE != 0) ? S_ACTIVE : S_VFRONT;
  localparam state_e AFTER_VSYNC = (V_BACK != 0) ? S_VBACK : AFTER_VBACK;
  localparam state_e FRAME_START = (VSYNC_LINES != 0) ? S_VSYNC : AFTER_VSYNC;

  function automatic logic [LC_W-1:0] last_line(input state_e s);
    case (s)
      S_VSYNC:  return LC_W'(VSYNC_LINES - 1);
      S_VBACK:  return LC_W'(V_BACK - 1);
      S_ACTIVE: return LC_W'(V_ACTIVE - 1);
      S_VFRONT: return LC_W'(V_FRONT - 1);
      default:  return '0;
    endcase
  endfunction

  function automatic state_e next_state(input state_e s);
    case (s)
      S_VSYNC:  return AFTER_VSYNC;
      S_VBACK:  return AFTER_VBACK;
      S_ACTIVE: return S_VFRONT;
      default:  return S_IDLE;
    endcase
  endfunction

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0: return 16'hFFFF;
      3'd1: return 16'hFFE0;
      3'd2: return 16'h07FF;
      3'd3: return 16'h07E0;
      3'd4: return 16'hF81F;
      3'd5: return 16'hF800;
      3'd6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic              ph_q, ph_d;
  logic [BC_W-1:0]   bc_q, bc_d;
  logic [LC_W-1:0]   lc_q, lc_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [2:0]        bar_q, bar_d;
  logic [1:0]        pat_q, pat_d;
  logic [15:0]       col_q, col_d;
  logic              href_q, href_d;
  logic              vsync_q, vsync_d;
  logic [7:0]        d_q, d_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic [7:0]        x_w;
  logic [15:0]       pix;

  // Next-state, counters and the bus value for the byte-time that starts at this edge.
  always_comb begin
    state_d      = state_q;
    bc_d         = bc_q;
    lc_d         = lc_q;
    seg_d        = seg_q;
    bar_d        = bar_q;
    pat_d        = pat_q;
    col_d        = col_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    ph_d         = ~ph_q;
    x_w          = '0;
    pix          = 16'h0000;

    if (ph_q) begin
      if (state_q == S_IDLE) begin
        bc_d = '0;
        lc_d = '0;
        if (enable) begin
          state_d = FRAME_START;
          pat_d   = pattern;
          col_d   = solid_color;
        end
      end else if (bc_q == BC_W'(LINE_LEN - 1)) begin
        bc_d = '0;
        if (lc_q == last_line(state_q)) begin
          lc_d    = '0;
          state_d = next_state(state_q);
          if (state_q == S_VFRONT) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 8'd1;
            if (enable) begin
              state_d = FRAME_START;
              pat_d   = pattern;
              col_d   = solid_color;
            end
          end
        end else begin
          lc_d = lc_q + LC_W'(1);
        end
      end else begin
        bc_d = bc_q + BC_W'(1);
      end

      // Bar index advances once per BAR_W pixels, restarting at each line.
      if (bc_d == '0) begin
        seg_d = '0;
        bar_d = '0;
      end else if (!bc_d[0]) begin
        if (seg_q == SEG_W'(BAR_W - 1)) begin
          seg_d = '0;
          bar_d = bar_q + 3'd1;
        end else begin
          seg_d = seg_q + SEG_W'(1);
        end
      end
    end

    x_w = 8'(bc_d >> 1);
    case (pat_d)
      2'd0: pix = bar_color(bar_d);
      2'd1: pix = {x_w[7:3], x_w[7:2], x_w[7:3]};
      2'd2: pix = col_d;
      default: pix = (((x_w ^ 8'(lc_d)) & 8'h10) != 8'h00) ? 16'hFFFF : 16'h0000;
    endcase

    href_d  = (state_d == S_ACTIVE) && (bc_d < BC_W'(ACT_BYTES));
    vsync_d = (state_d == S_VSYNC);
    busy_d  = (state_d != S_IDLE);
    d_d     = href_d ? (bc_d[0] ? pix[7:0] : pix[15:8]) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ph_q         <= 1'b0;
      bc_q         <= '0;
      lc_q         <= '0;
      seg_q        <= '0;
      bar_q        <= '0;
      pat_q        <= '0;
      col_q        <= '0;
      href_q       <= 1'b0;
      vsync_q      <= 1'b0;
      d_q          <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      bc_q         <= bc_d;
      lc_q         <= lc_d;
      seg_q        <= seg_d;
      bar_q        <= bar_d;
      pat_q        <= pat_d;
      col_q        <= col_d;
      href_q       <= href_d;
      vsync_q      <= vsync_d;
      d_q          <= d_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign CAM_PCLK   = ph_q;
  assign CAM_HREF   = href_q;
  assign CAM_VSYNC  = vsync_q;
  assign CAM_D      = d_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Bench for ov7670_stream_gen: frame-timeline reference model checked every clk, plus
// directed scenarios with literal expectations (bars, ramp, solid, enable drop, reset, wrap).
module tb_ov7670_stream_gen;

  localparam int unsigned HA  = 8;
  localparam int unsigned VA  = 2;
  localparam int unsigned HB  = 4;
  localparam int unsigned VSL = 1;
  localparam int unsigned VBK = 1;
  localparam int unsigned VFR = 1;
  localparam int unsigned LL  = 2 * HA + HB;
  localparam int unsigned FB  = (VSL + VBK + VA + VFR) * LL;

  localparam logic [7:0] BAR_BYTES [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                           8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  pattern;
  logic [15:0] solid_color;
  logic        CAM_PCLK, CAM_HREF, CAM_VSYNC, busy, frame_done;
  logic [7:0]  CAM_D, frame_cnt;

  always #5 clk = ~clk;

  ov7670_stream_gen #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VSYNC_LINES(VSL), .V_BACK(VBK), .V_FRONT(VFR)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pattern(pattern), .solid_color(solid_color),
    .CAM_PCLK(CAM_PCLK), .CAM_HREF(CAM_HREF), .CAM_VSYNC(CAM_VSYNC), .CAM_D(CAM_D),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  int vectors = 0;
  int miscompares = 0;
  int fail_prints = 0;

  // Reference model: position inside the frame as a plain byte-time index.
  bit          armed = 0;
  bit          m_ph, m_run, m_fd;
  int          m_t;
  logic [1:0]  m_pat;
  logic [15:0] m_col;
  logic [7:0]  m_fcnt;
  logic        s_rst, s_en;
  logic [1:0]  s_pat;
  logic [15:0] s_col;

  // Observation of the bus as a sink would see it on PCLK rise.
  logic [7:0]  cap_q[$];
  int          href_rises = 0, vs_rises = 0, fd_seen = 0;
  int          cyc = 0, fd_cyc = 0, vs_first = -1;
  logic        prev_pclk = 1'b0, prev_vs = 1'b0;

  function automatic logic [15:0] model_pixel(input int x, input int y, input logic [1:0] p,
                                              input logic [15:0] c);
    int bar, r, g;
    case (p)
      2'd0: begin
        bar = x / (HA / 8);
        case (bar)
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      2'd1: begin
        r = (x >> 3) & 31;
        g = (x >> 2) & 63;
        return 16'((r << 11) | (g << 5) | r);
      end
      2'd2: return c;
      default: return ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  task automatic model_step();
    bit upd;
    if (!s_rst) begin
      m_ph = 0; m_run = 0; m_t = 0; m_fcnt = 8'd0; m_fd = 0; armed = 1;
    end else begin
      upd  = m_ph;
      m_ph = ~m_ph;
      m_fd = 0;
      if (upd) begin
        if (!m_run) begin
          if (s_en) begin m_run = 1; m_t = 0; m_pat = s_pat; m_col = s_col; end
        end else if (m_t == int'(FB) - 1) begin
          m_fd   = 1;
          m_fcnt = m_fcnt + 8'd1;
          m_t    = 0;
          if (s_en) begin m_pat = s_pat; m_col = s_col; end
          else m_run = 0;
        end else begin
          m_t++;
        end
      end
    end
  endtask

  task automatic compare_cycle();
    int line, b;
    logic e_href, e_vs;
    logic [7:0] e_d;
    logic [15:0] p;
    logic [20:0] got, exp;
    line = m_t / LL;
    b    = m_t % LL;
    e_vs   = m_run && (line < VSL);
    e_href = m_run && (line >= VSL + VBK) && (line < VSL + VBK + VA) && (b < 2 * HA);
    e_d    = 8'h00;
    if (e_href) begin
      p   = model_pixel(b / 2, line - (VSL + VBK), m_pat, m_col);
      e_d = (b % 2 == 0) ? p[15:8] : p[7:0];
    end
    got = {CAM_PCLK, CAM_HREF, CAM_VSYNC, CAM_D, busy, frame_done, frame_cnt};
    exp = {m_ph, e_href, e_vs, e_d, m_run, m_fd, m_fcnt};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      if (fail_prints < 20) begin
        fail_prints++;
        $display("FAIL cycle %0d bus: got pclk=%b href=%b vs=%b d=%h busy=%b fd=%b cnt=%0d want pclk=%b href=%b vs=%b d=%h busy=%b fd=%b cnt=%0d",
                 cyc, CAM_PCLK, CAM_HREF, CAM_VSYNC, CAM_D, busy, frame_done, frame_cnt,
                 m_ph, e_href, e_vs, e_d, m_run, m_fd, m_fcnt);
      end
    end
  endtask

  // Model/compare/observe process, sampling 1 time unit after each rising edge.
  initial forever begin
    @(posedge clk);
    s_rst = rst; s_en = enable; s_pat = pattern; s_col = solid_color;
    #1;
    model_step();
    if (armed) begin
      compare_cycle();
      if (CAM_PCLK && !prev_pclk) begin
        if (CAM_HREF) begin href_rises++; cap_q.push_back(CAM_D); end
        if (CAM_VSYNC) vs_rises++;
      end
      if (CAM_VSYNC && !prev_vs && vs_first < 0) vs_first = cyc;
      if (frame_done) begin fd_seen++; fd_cyc = cyc; end
    end
    prev_pclk = CAM_PCLK;
    prev_vs   = CAM_VSYNC;
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic wait_cond(input string name, input int which, input int arg, input int budget);
    int n;
    bit ok;
    n = 0; ok = 0;
    while (!ok && n < budget) begin
      @(negedge clk);
      n++;
      case (which)
        0: ok = (CAM_HREF === 1'b1);
        1: ok = (busy === 1'b1);
        2: ok = (cap_q.size() >= arg);
        default: ok = (fd_seen >= arg);
      endcase
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: got timeout after %0d clk want condition reached", name, budget);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_pclk"}, 32'(CAM_PCLK), 32'd0);
    chk({name, "_href"}, 32'(CAM_HREF), 32'd0);
    chk({name, "_vsync"}, 32'(CAM_VSYNC), 32'd0);
    chk({name, "_d"}, 32'(CAM_D), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_fd"}, 32'(frame_done), 32'd0);
    chk({name, "_cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  initial begin
    int fd_base;
    rst = 1'b0; enable = 1'b0; pattern = 2'd0; solid_color = 16'h0000;
    repeat (5) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_vsync", 32'(CAM_VSYNC), 32'd0);

    // Frame 1: colour bars, line/frame timing.
    href_rises = 0; vs_rises = 0; vs_first = -1; cap_q.delete();
    enable = 1'b1;
    wait_cond("frame1", 3, 1, 500);
    chk("frame1_len_clk", 32'(fd_cyc - vs_first), 32'(2 * FB));
    chk("frame1_href_bytes", 32'(href_rises), 32'd32);
    chk("frame1_vsync_bytes", 32'(vs_rises), 32'd20);
    chk("frame1_cap_size", 32'(cap_q.size()), 32'd32);
    for (int i = 0; i < 16; i++) chk("bars_line0", 32'(cap_q[i]), 32'(BAR_BYTES[i]));
    chk("bars_line1_px7_hi", 32'(cap_q[30]), 32'h00);

    // Pattern change mid-stream: frame 2 stays bars, frame 3 is solid.
    pattern = 2'd2; solid_color = 16'h1234; cap_q.delete();
    wait_cond("frame2", 3, 2, 500);
    chk("frame2_px1_lo", 32'(cap_q[3]), 32'hE0);
    chk("frame2_px6_lo", 32'(cap_q[13]), 32'h1F);
    cap_q.delete();
    wait_cond("frame3_line1", 2, 20, 500);
    enable = 1'b0;
    wait_cond("frame3", 3, 3, 500);
    chk("solid_hi", 32'(cap_q[0]), 32'h12);
    chk("solid_lo", 32'(cap_q[1]), 32'h34);
    chk("solid_last", 32'(cap_q[31]), 32'h34);
    chk("drop_cnt", 32'(frame_cnt), 32'd3);
    repeat (4) @(negedge clk);
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_d", 32'(CAM_D), 32'd0);
    chk("drop_fd_count", 32'(fd_seen), 32'd3);

    // Gray ramp frame.
    pattern = 2'd1; cap_q.delete(); enable = 1'b1;
    wait_cond("ramp_start", 1, 0, 20);
    enable = 1'b0;
    wait_cond("ramp_frame", 3, 4, 500);
    chk("ramp_px0_lo", 32'(cap_q[1]), 32'h00);
    chk("ramp_px4_hi", 32'(cap_q[8]), 32'h00);
    chk("ramp_px4_lo", 32'(cap_q[9]), 32'h20);
    chk("ramp_px3_lo", 32'(cap_q[7]), 32'h00);

    // Checkerboard frame (model-checked).
    pattern = 2'd3; enable = 1'b1;
    wait_cond("chk_start", 1, 0, 20);
    enable = 1'b0;
    wait_cond("chk_frame", 3, 5, 500);

    // Reset in the middle of an active line.
    pattern = 2'd0; enable = 1'b1;
    wait_cond("mid_href", 0, 0, 500);
    @(negedge clk);
    rst = 1'b0; enable = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    rst = 1'b1;

    // 256 back-to-back frames wrap the frame counter.
    fd_base = fd_seen;
    enable = 1'b1;
    wait_cond("wrap255", 3, fd_base + 255, 255 * 2 * FB + 600);
    enable = 1'b0;
    wait_cond("wrap256", 3, fd_base + 256, 600);
    chk("wrap_cnt", 32'(frame_cnt), 32'd0);
    chk("wrap_fd_count", 32'(fd_seen - fd_base), 32'd256);
    repeat (4) @(negedge clk);
    chk("wrap_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
